// File: rtl/mem_port_arbiter.sv
//-----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch (IF)
// port and the data (MEM stage) port of the core. Data requests win
// arbitration. A starvation counter hands the slot to fetch after STARVE_MAX
// consecutive lost arbitrations. The block sequences fixed-latency (LAT)
// memory accesses, returns the responses, and generates the pipeline stalls.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset (rst low = reset)
//   if_req/if_addr     fetch request and address, held until if_gnt
//   if_kill            discard the outstanding or new fetch (branch flush)
//   if_gnt/if_valid    fetch accepted / fetch response pulse
//   if_rdata           fetch data, 0 unless if_valid
//   d_req/d_we/d_be    data request, write flag, byte enables
//   d_addr/d_wdata     data address and write data
//   d_gnt/d_valid      data accepted / response or write-ack pulse
//   d_rdata            read data, 0 for writes or unless d_valid
//   m_*                memory strobe, write, byte enables, address, write data;
//                      all 0 in cycles without a grant
//   m_rdata            memory read data, valid LAT cycles after m_en
//   stall_if/stall_mem freeze IF / freeze MEM and upstream
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int LAT        = 1,   // legal 1..4
  parameter int STARVE_MAX = 3    // legal 1..7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  // The busy states double as the owner flag: BUSY_IF = fetch owns the memory.
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [2:0] LAT_C    = 3'(LAT);
  localparam logic [2:0] STARVE_C = 3'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;
  logic [2:0] starve_cnt, starve_nxt;
  logic       kill_q, kill_nxt;
  logic       we_q, we_nxt;       // the data transaction in flight is a write

  logic busy, resp, slot, fetch_ok, gnt_d, gnt_if, kill_eff, resp_if, resp_d;

  assign busy     = (state != IDLE);
  assign resp     = busy && (lat_cnt == LAT_C);
  // No arbitration while in reset, so no output can rise during reset.
  assign slot     = rst && (!busy || resp);
  assign fetch_ok = if_req && !if_kill;
  assign gnt_d    = slot && d_req && !(fetch_ok && (starve_cnt == STARVE_C));
  assign gnt_if   = slot && fetch_ok && !gnt_d;
  // A kill arriving in the response cycle itself must still discard the data.
  assign kill_eff = kill_q || (if_kill && (state == BUSY_IF));
  assign resp_if  = resp && (state == BUSY_IF) && !kill_eff;
  assign resp_d   = resp && (state == BUSY_D);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; combinational blocks below use blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      kill_q     <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_nxt;
      kill_q     <= kill_nxt;
      we_q       <= we_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    starve_nxt  = starve_cnt;
    kill_nxt    = 1'b0;
    we_nxt      = we_q;

    if (gnt_d) begin
      state_nxt   = BUSY_D;
      lat_cnt_nxt = 3'd1;
      we_nxt      = d_we;
    end else if (gnt_if) begin
      state_nxt   = BUSY_IF;
      lat_cnt_nxt = 3'd1;
      we_nxt      = 1'b0;
    end else if (resp) begin
      state_nxt   = IDLE;
      lat_cnt_nxt = '0;
    end else if (busy) begin
      lat_cnt_nxt = lat_cnt + 3'd1;
    end

    // The flag lives until the end of the fetch's response cycle; a killed
    // fetch still runs its full latency.
    if ((state == BUSY_IF) && !resp)
      kill_nxt = kill_q || if_kill;

    if (gnt_if || !if_req)
      starve_nxt = '0;
    else if (gnt_d && fetch_ok && (starve_cnt != STARVE_C))
      starve_nxt = starve_cnt + 3'd1;
  end

  // Outputs: everything is gated by rst so reset clears them immediately.
  always_comb begin
    if_gnt    = 1'b0;
    if_valid  = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_valid   = 1'b0;
    d_rdata   = '0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_be      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    stall_if  = 1'b0;
    stall_mem = 1'b0;

    if (rst) begin
      if_gnt = gnt_if;
      d_gnt  = gnt_d;

      if (gnt_d) begin
        m_en    = 1'b1;
        m_we    = d_we;
        m_be    = d_be;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end else if (gnt_if) begin
        m_en   = 1'b1;
        m_be   = 4'hF;
        m_addr = if_addr;
      end

      if (resp_d) begin
        d_valid = 1'b1;
        d_rdata = we_q ? '0 : m_rdata;
      end
      if (resp_if) begin
        if_valid = 1'b1;
        if_rdata = m_rdata;
      end

      stall_if  = (if_req && !gnt_if) ||
                  ((state == BUSY_IF) && !resp_if && !kill_eff);
      stall_mem = (d_req && !gnt_d) || ((state == BUSY_D) && !resp_d);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
//-----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Three arbiter instances (LAT = 1, 2, 3; STARVE_MAX = 3) share one set of
// stimulus; each vector names the instance whose outputs it expects. Vectors
// are one clock cycle each: inputs change on the falling edge, outputs are
// compared just before the next rising edge. Hand-written sequences follow
// for a reset asserted between clock edges and a bounded wait on a response.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_be;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic        stall_if;
    logic        stall_mem;
  } out_t;

  typedef struct {
    string       name;
    int          sel;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_kill;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] m_rdata;
    out_t        exp;
    logic [5:0]  dc;     // don't-care flags {if_gnt,if_valid,d_gnt,d_valid,stall_if,stall_mem}
  } vec_t;

  logic        clk;
  logic        rst;
  logic        if_req, if_kill, d_req, d_we;
  logic [3:0]  d_be;
  logic [7:0]  if_addr, d_addr;
  logic [31:0] d_wdata, m_rdata;

  out_t [2:0] outs;
  int         sel;
  int         n_vec;
  int         n_bad;
  vec_t       tbl[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic        if_gnt, if_valid, d_gnt, d_valid, m_en, m_we, stall_if, stall_mem;
    logic [31:0] if_rdata, d_rdata, m_wdata;
    logic [3:0]  m_be;
    logic [7:0]  m_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(g + 1), .STARVE_MAX(3)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_kill  (if_kill),
      .if_gnt   (if_gnt),
      .if_valid (if_valid),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_be     (d_be),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_valid  (d_valid),
      .d_rdata  (d_rdata),
      .m_en     (m_en),
      .m_we     (m_we),
      .m_be     (m_be),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata),
      .stall_if (stall_if),
      .stall_mem(stall_mem)
    );

    assign outs[g] = {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
                      m_en, m_we, m_be, m_addr, m_wdata, stall_if, stall_mem};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected-output builder; fl = {if_gnt,if_valid,d_gnt,d_valid,stall_if,stall_mem}.
  function automatic out_t mk(input logic [5:0] fl, input logic [31:0] ifrd,
                              input logic [31:0] drd, input logic men, input logic mwe,
                              input logic [3:0] mbe, input logic [7:0] ma,
                              input logic [31:0] mwd);
    out_t o;
    o.if_gnt    = fl[5];
    o.if_valid  = fl[4];
    o.d_gnt     = fl[3];
    o.d_valid   = fl[2];
    o.stall_if  = fl[1];
    o.stall_mem = fl[0];
    o.if_rdata  = ifrd;
    o.d_rdata   = drd;
    o.m_en      = men;
    o.m_we      = mwe;
    o.m_be      = mbe;
    o.m_addr    = ma;
    o.m_wdata   = mwd;
    return o;
  endfunction

  function automatic out_t zo();
    return mk(6'b000000, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endfunction

  task automatic add(input string name, input int s, input logic r,
                     input logic ifr, input logic [7:0] ifa, input logic ifk,
                     input logic dr, input logic dwe, input logic [3:0] dbe,
                     input logic [7:0] da, input logic [31:0] dwd,
                     input logic [31:0] mrd, input out_t e,
                     input logic [5:0] dc = 6'b000000);
    vec_t v;
    v.name = name;  v.sel = s;       v.rst = r;
    v.if_req = ifr; v.if_addr = ifa; v.if_kill = ifk;
    v.d_req = dr;   v.d_we = dwe;    v.d_be = dbe;
    v.d_addr = da;  v.d_wdata = dwd; v.m_rdata = mrd;
    v.exp = e;      v.dc = dc;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    sel     = v.sel;
    rst     = v.rst;
    if_req  = v.if_req;
    if_addr = v.if_addr;
    if_kill = v.if_kill;
    d_req   = v.d_req;
    d_we    = v.d_we;
    d_be    = v.d_be;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    m_rdata = v.m_rdata;
  endtask

  function automatic bit diff(input string vn, input string f,
                              input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      $display("FAIL %s %s: got %0h, expected %0h", vn, f, got, want);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input out_t e, input logic [5:0] dc = 6'b000000);
    out_t a;
    bit   bad;
    a   = outs[sel];
    bad = 1'b0;
    n_vec++;
    if (!dc[5]) bad |= diff(name, "if_gnt",    32'(a.if_gnt),    32'(e.if_gnt));
    if (!dc[4]) bad |= diff(name, "if_valid",  32'(a.if_valid),  32'(e.if_valid));
    if (!dc[3]) bad |= diff(name, "d_gnt",     32'(a.d_gnt),     32'(e.d_gnt));
    if (!dc[2]) bad |= diff(name, "d_valid",   32'(a.d_valid),   32'(e.d_valid));
    if (!dc[1]) bad |= diff(name, "stall_if",  32'(a.stall_if),  32'(e.stall_if));
    if (!dc[0]) bad |= diff(name, "stall_mem", 32'(a.stall_mem), 32'(e.stall_mem));
    bad |= diff(name, "if_rdata", a.if_rdata,     e.if_rdata);
    bad |= diff(name, "d_rdata",  a.d_rdata,      e.d_rdata);
    bad |= diff(name, "m_en",     32'(a.m_en),    32'(e.m_en));
    bad |= diff(name, "m_we",     32'(a.m_we),    32'(e.m_we));
    bad |= diff(name, "m_be",     32'(a.m_be),    32'(e.m_be));
    bad |= diff(name, "m_addr",   32'(a.m_addr),  32'(e.m_addr));
    bad |= diff(name, "m_wdata",  a.m_wdata,      e.m_wdata);
    if (bad) n_bad++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;

    n_vec = 0; n_bad = 0; sel = 0;
    rst = 1'b1; if_req = 0; if_kill = 0; d_req = 0; d_we = 0;
    d_be = '0; if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;

    // ---- LAT=1 back-to-back fetches (reset row holds if_req high) ----
    add("A0_rst",   0, 0, 1, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      zo());
    add("A1_gnt",   0, 1, 1, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      mk(6'b100000, 32'h0, 32'h0, 1, 0, 4'hF, 8'h00, 32'h0));
    add("A2_b2b",   0, 1, 1, 8'h04, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h11111111, mk(6'b110000, 32'h11111111, 32'h0, 1, 0, 4'hF, 8'h04, 32'h0));
    add("A3_b2b",   0, 1, 1, 8'h08, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h22222222, mk(6'b110000, 32'h22222222, 32'h0, 1, 0, 4'hF, 8'h08, 32'h0));
    add("A4_last",  0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h33333333, mk(6'b010000, 32'h33333333, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    add("A5_idle",  0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h44444444, zo());
    // ---- LAT=1 starvation: d wins 3 slots, IF the 4th, d the 5th ----
    add("C0_rst",   0, 0, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      zo());
    add("C1_d",     0, 1, 1, 8'h20, 0, 1, 0, 4'hF, 8'h40, 32'h0, 32'h0,      mk(6'b001010, 32'h0, 32'h0, 1, 0, 4'hF, 8'h40, 32'h0));
    add("C2_d",     0, 1, 1, 8'h20, 0, 1, 0, 4'hF, 8'h40, 32'h0, 32'hA0,     mk(6'b001110, 32'h0, 32'hA0, 1, 0, 4'hF, 8'h40, 32'h0));
    add("C3_d",     0, 1, 1, 8'h20, 0, 1, 0, 4'hF, 8'h40, 32'h0, 32'hA1,     mk(6'b001110, 32'h0, 32'hA1, 1, 0, 4'hF, 8'h40, 32'h0));
    add("C4_if",    0, 1, 1, 8'h20, 0, 1, 0, 4'hF, 8'h40, 32'h0, 32'hA2,     mk(6'b100101, 32'h0, 32'hA2, 1, 0, 4'hF, 8'h20, 32'h0));
    add("C5_d",     0, 1, 1, 8'h24, 0, 1, 0, 4'hF, 8'h40, 32'h0, 32'hB0,     mk(6'b011010, 32'hB0, 32'h0, 1, 0, 4'hF, 8'h40, 32'h0));
    add("C6_resp",  0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'hA3,     mk(6'b000100, 32'h0, 32'hA3, 0, 0, 4'h0, 8'h00, 32'h0));
    // ---- LAT=3 simultaneous requests from IDLE ----
    add("B0_rst",   2, 0, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      zo());
    add("B1_d",     2, 1, 1, 8'h30, 0, 1, 0, 4'hF, 8'h40, 32'h0, 32'h0,      mk(6'b001010, 32'h0, 32'h0, 1, 0, 4'hF, 8'h40, 32'h0));
    add("B2_wait",  2, 1, 1, 8'h30, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      mk(6'b000011, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    add("B3_wait",  2, 1, 1, 8'h30, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      mk(6'b000011, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    add("B4_swap",  2, 1, 1, 8'h30, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h5555AAAA, mk(6'b100100, 32'h0, 32'h5555AAAA, 1, 0, 4'hF, 8'h30, 32'h0), 6'b000010);
    add("B5_wait",  2, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      mk(6'b000010, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    add("B6_wait",  2, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      mk(6'b000010, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    add("B7_ifv",   2, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h12345678, mk(6'b010000, 32'h12345678, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    // ---- LAT=2 killed fetch; pending read granted in its response cycle ----
    add("D0_rst",   1, 0, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      zo());
    add("D1_if",    1, 1, 1, 8'h50, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      mk(6'b100000, 32'h0, 32'h0, 1, 0, 4'hF, 8'h50, 32'h0));
    add("D2_kill",  1, 1, 0, 8'h00, 1, 1, 0, 4'hF, 8'h44, 32'h0, 32'h0,      mk(6'b000001, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    add("D3_d",     1, 1, 0, 8'h00, 0, 1, 0, 4'hF, 8'h44, 32'h0, 32'hCAFE0000, mk(6'b001000, 32'h0, 32'h0, 1, 0, 4'hF, 8'h44, 32'h0));
    add("D4_wait",  1, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      mk(6'b000001, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    add("D5_dv",    1, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0BADF00D, mk(6'b000100, 32'h0, 32'h0BADF00D, 0, 0, 4'h0, 8'h00, 32'h0));
    // ---- LAT=2 partial write ----
    add("E1_wr",    1, 1, 0, 8'h00, 0, 1, 1, 4'h3, 8'h10, 32'hDEADBEEF, 32'h0, mk(6'b001000, 32'h0, 32'h0, 1, 1, 4'h3, 8'h10, 32'hDEADBEEF));
    add("E2_wait",  1, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'hFFFFFFFF, mk(6'b000001, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    add("E3_ack",   1, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'hFFFFFFFF, mk(6'b000100, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    // ---- LAT=3 reset in cycle 1 of BUSY_D ----
    add("F0_rst",   2, 0, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      zo());
    add("F1_d",     2, 1, 0, 8'h00, 0, 1, 0, 4'hF, 8'h60, 32'h0, 32'h0,      mk(6'b001000, 32'h0, 32'h0, 1, 0, 4'hF, 8'h60, 32'h0));
    add("F2_rst",   2, 0, 1, 8'h70, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      zo());
    add("F3_first", 2, 1, 1, 8'h70, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h0,      mk(6'b100000, 32'h0, 32'h0, 1, 0, 4'hF, 8'h70, 32'h0));
    add("F4_nodv",  2, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 32'h0, 32'h77777777, mk(6'b000010, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));

    #1 rst = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #4;
      check(tbl[i].name, tbl[i].exp, tbl[i].dc);
    end

    // ---- reset asserted between clock edges, mid fetch (LAT=3) ----
    sel = 2;
    @(negedge clk);
    rst = 1'b0; if_req = 0; if_kill = 0; d_req = 0; d_we = 0; d_be = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = 32'h99999999;
    @(negedge clk);
    rst = 1'b1; if_req = 1'b1; if_addr = 8'h80;
    @(negedge clk);
    if_req = 1'b0;
    #2;
    check("H1_busy", mk(6'b000010, 32'h0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0));
    #1 rst = 1'b0;
    #1;
    check("H1_async_rst", zo());
    @(negedge clk);
    rst = 1'b1;

    // ---- bounded wait for a LAT=3 read response ----
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 8'h90; m_rdata = 32'h0;
    #4;
    check("H2_grant", mk(6'b001000, 32'h0, 32'h0, 1, 0, 4'hF, 8'h90, 32'h0));
    @(negedge clk);
    d_req = 1'b0; d_be = '0; d_addr = '0;
    seen = 1'b0;
    for (n = 1; n <= 8; n++) begin
      #4;
      if (outs[2].d_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!seen || n != 3) begin
      $display("FAIL H2_latency: d_valid seen=%0d after %0d cycles, expected after 3", seen, n);
      n_bad++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
